// File: rtl/ir_pkg.sv
// ir_pkg: shared types and constants for the NEC infrared receiver.
//   - nec_state_e : decoder FSM states
//   - *_MIN/*_MAX : inclusive timing windows in microseconds
//   - CNT_W       : width of the saturating duration counter (ticks)
//   - us_to_ticks_lo/hi : convert a window bound in us to tick units,
//                         rounding inward so the window never widens
package ir_pkg;

    localparam int unsigned CNT_W = 15;

    localparam int unsigned LEAD_MARK_MIN  = 6750;
    localparam int unsigned LEAD_MARK_MAX  = 11250;
    localparam int unsigned LEAD_SPACE_MIN = 3375;
    localparam int unsigned LEAD_SPACE_MAX = 5625;
    localparam int unsigned REP_SPACE_MIN  = 1688;
    localparam int unsigned REP_SPACE_MAX  = 2812;
    localparam int unsigned BIT_MIN        = 281;
    localparam int unsigned BIT_MAX        = 844;
    localparam int unsigned ONE_MIN        = 1266;
    localparam int unsigned ONE_MAX        = 2109;
    localparam int unsigned TIMEOUT_US     = 12000;

    typedef enum logic [2:0] {
        StIdle,
        StLeadMark,
        StLeadSpace,
        StBitMark,
        StBitSpace,
        StStopMark,
        StRepMark
    } nec_state_e;

    function automatic int unsigned us_to_ticks_lo(int unsigned us, int unsigned tick_us);
        return (us + tick_us - 1) / tick_us;
    endfunction

    function automatic int unsigned us_to_ticks_hi(int unsigned us, int unsigned tick_us);
        return us / tick_us;
    endfunction

    function automatic logic in_win(logic [CNT_W-1:0] d, int unsigned lo, int unsigned hi);
        return (32'(d) >= lo) && (32'(d) <= hi);
    endfunction

endpackage

// File: rtl/ir_rx_filter.sv
// ir_rx_filter: front end for the raw IR receiver line.
//   Synchronises ir_rx_i (2 FFs), divides clk_i down to a tick of TICK_US
//   microseconds and only accepts a level change once the synchronised input
//   has differed from the filtered level for GLITCH_US worth of consecutive ticks.
// Ports:
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   ir_rx_i         : raw receiver output (low = mark)
//   tick_o          : one-cycle pulse every TICK_US microseconds
//   level_o         : filtered level (1 = space), resets to 1
//   rise_o, fall_o  : one-cycle pulses coincident with a change of level_o
module ir_rx_filter #(
    parameter int unsigned CLK_HZ    = 74_250_000,
    parameter int unsigned GLITCH_US = 8,
    parameter int unsigned TICK_US   = 1
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic ir_rx_i,
    output logic tick_o,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Rounded clk cycles per tick, never below one.
    localparam longint unsigned PreRaw =
        (64'(CLK_HZ) * 64'(TICK_US) + 64'd500_000) / 64'd1_000_000;
    localparam int unsigned Prescale = (PreRaw == 0) ? 1 : 32'(PreRaw);
    localparam int unsigned DivW     = (Prescale > 1) ? $clog2(Prescale) : 1;
    localparam int unsigned GlitchT  = (GLITCH_US / TICK_US > 0) ? GLITCH_US / TICK_US : 1;
    localparam int unsigned GlW      = $clog2(GlitchT + 1);

    logic            rx_meta_q, rx_sync_q;
    logic [DivW-1:0] div_q, div_d;
    logic [GlW-1:0]  glitch_q, glitch_d;
    logic            level_q, level_d;
    logic            rise_q, fall_q;
    logic            tick;

    assign tick = (div_q == DivW'(Prescale - 1));

    always_comb begin
        div_d    = tick ? '0 : div_q + 1'b1;
        level_d  = level_q;
        glitch_d = glitch_q;
        if (rx_sync_q == level_q) begin
            glitch_d = '0;
        end else if (tick) begin
            if (glitch_q == GlW'(GlitchT - 1)) begin
                level_d  = rx_sync_q;
                glitch_d = '0;
            end else begin
                glitch_d = glitch_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            div_q     <= '0;
            glitch_q  <= '0;
            level_q   <= 1'b1;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            rx_meta_q <= ir_rx_i;
            rx_sync_q <= rx_meta_q;
            div_q     <= div_d;
            glitch_q  <= glitch_d;
            level_q   <= level_d;
            rise_q    <= level_d & ~level_q;
            fall_q    <= ~level_d & level_q;
        end
    end

    assign tick_o  = tick;
    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ir_nec_rx.sv
// ir_nec_rx: NEC infrared frame / repeat-code decoder with a one-entry
// valid/ready output buffer.
// Ports:
//   clk_i, reset_ni      : clock, asynchronous active-low reset
//   enable_i             : 1 = receiver active
//   ir_rx_i              : raw IR receiver output (low = mark)
//   ir_rx_disable_o      : registered ~enable_i, to the IR port
//   ir_tx_o              : IR LED drive, always 0
//   out_valid_o/ready_i  : event handshake
//   out_addr_o, out_cmd_o, out_repeat_o : decoded event
//   drop_o               : pulse, event lost because the buffer was full
//   err_o                : pulse, frame aborted
// TICK_US sets the timing granularity; 1 gives microsecond resolution.
module ir_nec_rx
    import ir_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 74_250_000,
    parameter int unsigned GLITCH_US = 8,
    parameter int unsigned TICK_US   = 1
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       enable_i,
    input  logic       ir_rx_i,
    output logic       ir_rx_disable_o,
    output logic       ir_tx_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_addr_o,
    output logic [7:0] out_cmd_o,
    output logic       out_repeat_o,
    output logic       drop_o,
    output logic       err_o
);

    localparam int unsigned LeadMarkLo  = us_to_ticks_lo(LEAD_MARK_MIN, TICK_US);
    localparam int unsigned LeadMarkHi  = us_to_ticks_hi(LEAD_MARK_MAX, TICK_US);
    localparam int unsigned LeadSpaceLo = us_to_ticks_lo(LEAD_SPACE_MIN, TICK_US);
    localparam int unsigned LeadSpaceHi = us_to_ticks_hi(LEAD_SPACE_MAX, TICK_US);
    localparam int unsigned RepSpaceLo  = us_to_ticks_lo(REP_SPACE_MIN, TICK_US);
    localparam int unsigned RepSpaceHi  = us_to_ticks_hi(REP_SPACE_MAX, TICK_US);
    localparam int unsigned BitLo       = us_to_ticks_lo(BIT_MIN, TICK_US);
    localparam int unsigned BitHi       = us_to_ticks_hi(BIT_MAX, TICK_US);
    localparam int unsigned OneLo       = us_to_ticks_lo(ONE_MIN, TICK_US);
    localparam int unsigned OneHi       = us_to_ticks_hi(ONE_MAX, TICK_US);
    localparam int unsigned TimeoutT    = us_to_ticks_hi(TIMEOUT_US, TICK_US);

    logic tick, level, rise, fall;

    ir_rx_filter #(
        .CLK_HZ    (CLK_HZ),
        .GLITCH_US (GLITCH_US),
        .TICK_US   (TICK_US)
    ) u_filter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .ir_rx_i  (ir_rx_i),
        .tick_o   (tick),
        .level_o  (level),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    nec_state_e       state_q;
    logic [CNT_W-1:0] dur_q;
    logic [31:0]      shift_q;
    logic [4:0]       bit_cnt_q;
    logic             have_last_q;
    logic [7:0]       last_addr_q, last_cmd_q;
    logic             out_valid_q, out_repeat_q, drop_q, err_q, rx_disable_q;
    logic [7:0]       out_addr_q, out_cmd_q;

    logic win_lead_mark, win_lead_space, win_rep_space, win_bit, win_one;
    logic checks_ok, full_ok, rep_ok, emit, timeout;
    logic [7:0] emit_addr, emit_cmd;

    always_comb begin
        win_lead_mark  = in_win(dur_q, LeadMarkLo, LeadMarkHi);
        win_lead_space = in_win(dur_q, LeadSpaceLo, LeadSpaceHi);
        win_rep_space  = in_win(dur_q, RepSpaceLo, RepSpaceHi);
        win_bit        = in_win(dur_q, BitLo, BitHi);
        win_one        = in_win(dur_q, OneLo, OneHi);
        // Byte layout after 32 LSB-first bits: {~cmd, cmd, ~addr, addr}.
        checks_ok = ((shift_q[7:0] ^ shift_q[15:8]) == 8'hFF) &&
                    ((shift_q[23:16] ^ shift_q[31:24]) == 8'hFF);
        full_ok   = enable_i && (state_q == StStopMark) && rise && win_bit && checks_ok;
        rep_ok    = enable_i && (state_q == StRepMark) && rise && win_bit && have_last_q;
        emit      = full_ok || rep_ok;
        emit_addr = full_ok ? shift_q[7:0]   : last_addr_q;
        emit_cmd  = full_ok ? shift_q[23:16] : last_cmd_q;
        // A space (level high) running too long anywhere inside a frame.
        timeout   = level && !rise && !fall && (state_q != StIdle) &&
                    (32'(dur_q) > TimeoutT);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= StIdle;
            dur_q        <= '0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            have_last_q  <= 1'b0;
            last_addr_q  <= '0;
            last_cmd_q   <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_cmd_q    <= '0;
            out_repeat_q <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
            rx_disable_q <= 1'b1;
        end else begin
            rx_disable_q <= ~enable_i;
            err_q        <= 1'b0;
            drop_q       <= 1'b0;

            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            if (emit) begin
                if (!out_valid_q || out_ready_i) begin
                    out_valid_q  <= 1'b1;
                    out_addr_q   <= emit_addr;
                    out_cmd_q    <= emit_cmd;
                    out_repeat_q <= rep_ok;
                end else begin
                    drop_q <= 1'b1;
                end
            end
            if (full_ok) begin
                have_last_q <= 1'b1;
                last_addr_q <= shift_q[7:0];
                last_cmd_q  <= shift_q[23:16];
            end

            if (!enable_i) begin
                state_q   <= StIdle;
                dur_q     <= '0;
                shift_q   <= '0;
                bit_cnt_q <= '0;
            end else begin
                if (rise || fall) begin
                    dur_q <= '0;
                end else if (tick && (dur_q != '1)) begin
                    dur_q <= dur_q + 1'b1;
                end

                if (timeout) begin
                    err_q   <= 1'b1;
                    state_q <= StIdle;
                end else begin
                    unique case (state_q)
                        StIdle: begin
                            if (fall) state_q <= StLeadMark;
                        end
                        StLeadMark: begin
                            if (rise) begin
                                if (win_lead_mark) begin
                                    state_q <= StLeadSpace;
                                end else begin
                                    err_q   <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        end
                        StLeadSpace: begin
                            if (fall) begin
                                if (win_lead_space) begin
                                    state_q   <= StBitMark;
                                    bit_cnt_q <= '0;
                                    shift_q   <= '0;
                                end else if (win_rep_space) begin
                                    state_q <= StRepMark;
                                end else begin
                                    err_q   <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        end
                        StBitMark: begin
                            if (rise) begin
                                if (win_bit) begin
                                    state_q <= StBitSpace;
                                end else begin
                                    err_q   <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        end
                        StBitSpace: begin
                            if (fall) begin
                                if (win_bit || win_one) begin
                                    shift_q   <= {win_one, shift_q[31:1]};
                                    bit_cnt_q <= bit_cnt_q + 1'b1;
                                    state_q   <= (bit_cnt_q == 5'd31) ? StStopMark : StBitMark;
                                end else begin
                                    err_q   <= 1'b1;
                                    state_q <= StIdle;
                                end
                            end
                        end
                        StStopMark: begin
                            if (rise) begin
                                state_q <= StIdle;
                                if (!full_ok) err_q <= 1'b1;
                            end
                        end
                        StRepMark: begin
                            // A valid repeat without a stored frame is ignored quietly.
                            if (rise) begin
                                state_q <= StIdle;
                                if (!win_bit) err_q <= 1'b1;
                            end
                        end
                        default: state_q <= StIdle;
                    endcase
                end
            end
        end
    end

    assign ir_rx_disable_o = rx_disable_q;
    assign ir_tx_o         = 1'b0;
    assign out_valid_o     = out_valid_q;
    assign out_addr_o      = out_addr_q;
    assign out_cmd_o       = out_cmd_q;
    assign out_repeat_o    = out_repeat_q;
    assign drop_o          = drop_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_ir_nec_rx.sv
// Directed bench for ir_nec_rx. The DUT runs with an 8 us tick, one tick per
// clock cycle, and a 16 us glitch filter, so all protocol durations below are
// in 8 us cycles and a one-cycle pulse is the sub-filter glitch.
module tb_ir_nec_rx;

    localparam int unsigned CLK_HZ    = 125_000;
    localparam int unsigned GLITCH_US = 16;
    localparam int unsigned TICK_US   = 8;

    localparam int LeadMark  = 1125; // 9000 us
    localparam int LeadSpace = 562;  // 4496 us
    localparam int RepSpace  = 281;  // 2248 us
    localparam int BitMark   = 70;   // 560 us
    localparam int ZeroSpace = 70;   // 560 us
    localparam int OneSpace  = 211;  // 1688 us
    localparam int BadSpace  = 125;  // 1000 us

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       ir_rx = 1'b1;
    logic       out_ready = 1'b1;
    logic       ir_rx_disable, ir_tx, out_valid, out_repeat, drop, err;
    logic [7:0] out_addr, out_cmd;

    always #5 clk = ~clk;

    ir_nec_rx #(
        .CLK_HZ    (CLK_HZ),
        .GLITCH_US (GLITCH_US),
        .TICK_US   (TICK_US)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .enable_i        (enable),
        .ir_rx_i         (ir_rx),
        .ir_rx_disable_o (ir_rx_disable),
        .ir_tx_o         (ir_tx),
        .out_valid_o     (out_valid),
        .out_ready_i     (out_ready),
        .out_addr_o      (out_addr),
        .out_cmd_o       (out_cmd),
        .out_repeat_o    (out_repeat),
        .drop_o          (drop),
        .err_o           (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Event monitor, sampled mid-cycle.
    int         err_cnt = 0, drop_cnt = 0, hs_cnt = 0, valid_cycles = 0;
    logic [7:0] hs_addr = 8'h00, hs_cmd = 8'h00;
    logic       hs_rep = 1'b0;

    always @(negedge clk) begin
        if (err) err_cnt <= err_cnt + 1;
        if (drop) drop_cnt <= drop_cnt + 1;
        if (out_valid) valid_cycles <= valid_cycles + 1;
        if (out_valid && out_ready) begin
            hs_cnt  <= hs_cnt + 1;
            hs_addr <= out_addr;
            hs_cmd  <= out_cmd;
            hs_rep  <= out_repeat;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic seg(input logic lvl, input int n, input bit gl);
        ir_rx = lvl;
        if (gl && n > 40) begin
            wait_cycles(20);
            ir_rx = ~lvl;
            wait_cycles(1);
            ir_rx = lvl;
            wait_cycles(n - 21);
        end else begin
            wait_cycles(n);
        end
    endtask

    function automatic logic [31:0] frame(input logic [7:0] a, input logic [7:0] c);
        return {~c, c, ~a, a};
    endfunction

    // Lead, nbits data bits (bit bad_idx gets a bad space), then a closing
    // mark when the frame is complete or a bad space must be terminated.
    task automatic send_frame(input logic [31:0] data, input int nbits, input int bad_idx,
                              input bit gl);
        seg(1'b0, LeadMark, gl);
        seg(1'b1, LeadSpace, gl);
        for (int i = 0; i < nbits; i++) begin
            seg(1'b0, BitMark, gl);
            if (i == bad_idx) seg(1'b1, BadSpace, gl);
            else seg(1'b1, data[i] ? OneSpace : ZeroSpace, gl);
        end
        if (nbits == 32 || bad_idx >= 0) seg(1'b0, BitMark, gl);
        ir_rx = 1'b1;
    endtask

    task automatic send_repeat();
        seg(1'b0, LeadMark, 1'b0);
        seg(1'b1, RepSpace, 1'b0);
        seg(1'b0, BitMark, 1'b0);
        ir_rx = 1'b1;
    endtask

    initial begin
        // Reset values.
        wait_cycles(3);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_addr), 32'd0);
        check("rst_cmd", 32'(out_cmd), 32'd0);
        check("rst_repeat", 32'(out_repeat), 32'd0);
        check("rst_drop_err", 32'({drop, err}), 32'd0);
        check("rst_disable", 32'(ir_rx_disable), 32'd1);
        check("rst_tx", 32'(ir_tx), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        wait_cycles(5);
        check("en_disable", 32'(ir_rx_disable), 32'd0);

        // Repeat code with no stored frame: ignored, no err.
        send_repeat();
        wait_cycles(20);
        check("rep_nolast_hs", 32'(hs_cnt), 32'd0);
        check("rep_nolast_err", 32'(err_cnt), 32'd0);

        // Valid frame 04/08.
        send_frame(frame(8'h04, 8'h08), 32, -1, 1'b0);
        wait_cycles(20);
        check("f1_hs", 32'(hs_cnt), 32'd1);
        check("f1_valid_cycles", 32'(valid_cycles), 32'd1);
        check("f1_addr", 32'(hs_addr), 32'h04);
        check("f1_cmd", 32'(hs_cmd), 32'h08);
        check("f1_rep", 32'(hs_rep), 32'd0);
        check("f1_err", 32'(err_cnt), 32'd0);
        check("f1_valid_low", 32'(out_valid), 32'd0);

        // Repeat after the frame.
        wait_cycles(1000);
        send_repeat();
        wait_cycles(20);
        check("r1_hs", 32'(hs_cnt), 32'd2);
        check("r1_addr", 32'(hs_addr), 32'h04);
        check("r1_cmd", 32'(hs_cmd), 32'h08);
        check("r1_rep", 32'(hs_rep), 32'd1);

        // Inverse-command mismatch.
        send_frame({8'hF6, 8'h08, 8'hFB, 8'h04}, 32, -1, 1'b0);
        wait_cycles(20);
        check("badinv_err", 32'(err_cnt), 32'd1);
        check("badinv_hs", 32'(hs_cnt), 32'd2);

        // 1000 us bit space at bit 5.
        send_frame(frame(8'h04, 8'h08), 6, 5, 1'b0);
        wait_cycles(20);
        check("badsp_err", 32'(err_cnt), 32'd2);
        check("badsp_hs", 32'(hs_cnt), 32'd2);

        // Next frame decodes despite glitches in every mark and space.
        wait_cycles(50);
        send_frame(frame(8'h5A, 8'hC3), 32, -1, 1'b1);
        wait_cycles(20);
        check("gl_hs", 32'(hs_cnt), 32'd3);
        check("gl_addr", 32'(hs_addr), 32'h5A);
        check("gl_cmd", 32'(hs_cmd), 32'hC3);
        check("gl_err", 32'(err_cnt), 32'd2);

        // Back-pressure: first frame held, second dropped.
        out_ready = 1'b0;
        send_frame(frame(8'h01, 8'h02), 32, -1, 1'b0);
        wait_cycles(20);
        check("bp1_valid", 32'(out_valid), 32'd1);
        check("bp1_addr", 32'(out_addr), 32'h01);
        check("bp1_cmd", 32'(out_cmd), 32'h02);
        send_frame(frame(8'h03, 8'h04), 32, -1, 1'b0);
        wait_cycles(20);
        check("bp2_drop", 32'(drop_cnt), 32'd1);
        check("bp2_valid", 32'(out_valid), 32'd1);
        check("bp2_addr", 32'(out_addr), 32'h01);
        check("bp2_cmd", 32'(out_cmd), 32'h02);
        out_ready = 1'b1;
        wait_cycles(1);
        check("bp_hs", 32'(hs_cnt), 32'd4);
        check("bp_hs_addr", 32'(hs_addr), 32'h01);
        check("bp_valid_clr", 32'(out_valid), 32'd0);

        // Disable after 16 bits.
        send_frame(frame(8'h10, 8'h20), 16, -1, 1'b0);
        seg(1'b0, 30, 1'b0);
        enable = 1'b0;
        check("dis_latency", 32'(ir_rx_disable), 32'd0);
        wait_cycles(1);
        check("dis_disable", 32'(ir_rx_disable), 32'd1);
        ir_rx = 1'b1;
        wait_cycles(200);
        check("dis_err", 32'(err_cnt), 32'd2);
        check("dis_hs", 32'(hs_cnt), 32'd4);
        enable = 1'b1;
        wait_cycles(10);
        check("reen_disable", 32'(ir_rx_disable), 32'd0);
        out_ready = 1'b0;
        send_frame(frame(8'h10, 8'h20), 32, -1, 1'b0);
        wait_cycles(20);
        check("reen_valid", 32'(out_valid), 32'd1);
        check("reen_addr", 32'(out_addr), 32'h10);
        check("reen_cmd", 32'(out_cmd), 32'h20);
        check("reen_err", 32'(err_cnt), 32'd2);

        // Reset mid-frame, with an event still pending.
        send_frame(frame(8'h55, 8'hAA), 8, -1, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_addr_cmd", 32'({out_addr, out_cmd}), 32'd0);
        check("mrst_rep_drop_err", 32'({out_repeat, drop, err}), 32'd0);
        check("mrst_disable", 32'(ir_rx_disable), 32'd1);
        ir_rx = 1'b1;
        wait_cycles(5);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        wait_cycles(5);
        // Stored frame is gone, so a repeat yields nothing.
        send_repeat();
        wait_cycles(20);
        check("mrst_rep_hs", 32'(hs_cnt), 32'd4);
        check("mrst_rep_err", 32'(err_cnt), 32'd2);
        check("mrst_rep_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
